sopc_unified_mem: RTL and testbench

Parametrised successor to the split instruction-ROM/data-RAM memory side of the minimal SOPC. It provides one single-ported unified memory shared by the CPU fetch port and load/store port, with an arbiter in front of it. Access latency is configurable (wait states) and byte-lane writes are supported. Per-port stall requests let the CPU pipeline hold while an access is outstanding; it sits between the openmips core and the top level.

---
 rtl/sopc_unified_mem_pkg.sv | 18 +
 rtl/sopc_mem_array.sv | 31 +++
 rtl/sopc_unified_mem.sv | 134 +++++++++++++
 tb/tb_sopc_unified_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sopc_unified_mem_pkg.sv
// Shared definitions for the unified SOPC memory: FSM states, port ids, counter sizing.
package sopc_unified_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Wait-state counter holds LATENCY-1; keep at least one bit for LATENCY=1.
    function automatic int cnt_w(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/sopc_mem_array.sv
// Single-port word array with per-byte-lane write enables and a registered read.
module sopc_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   sel_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_W/8; i++)
                    if (sel_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end else begin
                rdata_q <= mem[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sopc_unified_mem.sv
// Unified single-ported memory shared by fetch and load/store ports behind an arbiter.
// Optional SOPC_MEM_ROUND_ROBIN_EN: alternate grants on contention instead of data-first.
module sopc_unified_mem
    import sopc_unified_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ce,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_data,
    output logic                  if_ready,
    input  logic                  d_ce,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_sel,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready,
    output logic                  if_stall_req,
    output logic                  d_stall_req,
    output logic                  busy
);

    localparam int SEL_W = DATA_W/8;
    localparam int CW    = cnt_w(LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY-1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  port_q, we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DATA_W-1:0]     wdata_q, if_data_q, d_data_q;
    logic [DATA_W-1:0]     arr_rdata;
    logic                  grant, capture, mem_en;
`ifdef SOPC_MEM_ROUND_ROBIN_EN
    logic                  ptr_q;
`endif

    logic unused_addr;
    assign unused_addr = ^{if_addr[ADDR_W-1:DEPTH_LOG2+2], if_addr[1:0],
                           d_addr[ADDR_W-1:DEPTH_LOG2+2], d_addr[1:0]};

`ifdef SOPC_MEM_ROUND_ROBIN_EN
    assign grant = (if_ce && d_ce) ? ptr_q : (d_ce ? PORT_D : PORT_IF);
`else
    assign grant = d_ce ? PORT_D : PORT_IF;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_D;
            we_q      <= 1'b0;
            idx_q     <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_data_q  <= '0;
`ifdef SOPC_MEM_ROUND_ROBIN_EN
            ptr_q     <= PORT_D;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                port_q  <= grant;
                we_q    <= (grant == PORT_D) && d_we;
                idx_q   <= (grant == PORT_D) ? d_addr[DEPTH_LOG2+1:2] : if_addr[DEPTH_LOG2+1:2];
                sel_q   <= d_sel;
                wdata_q <= d_wdata;
`ifdef SOPC_MEM_ROUND_ROBIN_EN
                ptr_q   <= ~grant;
`endif
            end
            // Hold the read word past RESP so the port output stays stable afterwards.
            if (if_ready && !we_q) if_data_q <= arr_rdata;
            if (d_ready && !we_q)  d_data_q  <= arr_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_ce || d_ce) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        if_ready     = (state_q == S_RESP) && (port_q == PORT_IF);
        d_ready      = (state_q == S_RESP) && (port_q == PORT_D);
        // Gate with reset so an access abandoned by reset never commits.
        mem_en       = rst && (state_q == S_ACCESS) && (cnt_q == '0);
        if_data      = (if_ready && !we_q) ? arr_rdata : if_data_q;
        d_rdata      = (d_ready && !we_q) ? arr_rdata : d_data_q;
        if_stall_req = if_ce && !if_ready;
        d_stall_req  = d_ce && !d_ready;
    end

    sopc_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (we_q),
        .sel_i   (sel_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

endmodule

// File: tb/tb_sopc_unified_mem.sv
// Directed plus randomized checks of sopc_unified_mem against a word-array model.
module tb_sopc_unified_mem;

    localparam int LAT = 3;
    localparam int DL2 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce, if_ready, d_ce, d_we, d_ready;
    logic        if_stall_req, d_stall_req, busy;
    logic [31:0] if_addr, if_data, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [2**DL2];
    logic [31:0] exp_ifd, exp_drd;
    bit          ptr_m;

    always #5 clk = ~clk;

    sopc_unified_mem #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DL2), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_ce(if_ce), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
        .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .if_stall_req(if_stall_req), .d_stall_req(d_stall_req), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % (2**DL2));
    endfunction

    // Model: apply one granted access to the word array and port output registers.
    task automatic model_commit(input bit isd, input bit we, input logic [31:0] a,
                                input logic [3:0] sel, input logic [31:0] wd);
        int i;
        i = widx(a);
        if (isd && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mem_m[i] = (mem_m[i] & ~(32'hFF << (8*b))) | (wd & (32'hFF << (8*b)));
        end else if (isd) exp_drd = mem_m[i];
        else              exp_ifd = mem_m[i];
        ptr_m = !isd;
    endtask

    task automatic access(input bit isd, input bit we, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] wd);
        bit seen;
        bit stall_ok;
        @(posedge clk); #1;
        if (isd) begin
            d_ce = 1'b1; d_we = we; d_addr = a; d_sel = sel; d_wdata = wd;
        end else begin
            if_ce = 1'b1; if_addr = a;
        end
        model_commit(isd, we, a, sel, wd);
        seen = 0;
        stall_ok = 1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (isd ? d_ready : if_ready) begin
                seen = 1;
                chk("latency", 32'(k), 32'(LAT+1));
                chk("other_ready", {31'd0, isd ? if_ready : d_ready}, 32'd0);
                chk("stall_at_ready", {31'd0, isd ? d_stall_req : if_stall_req}, 32'd0);
                if (isd) chk("d_rdata", d_rdata, exp_drd);
                else     chk("if_data", if_data, exp_ifd);
                d_ce = 1'b0; if_ce = 1'b0;
            end else if (!(isd ? d_stall_req : if_stall_req)) stall_ok = 0;
        end
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            d_ce = 1'b0; if_ce = 1'b0;
        end
        chk("stall_before_ready", {31'd0, stall_ok}, 32'd1);
    endtask

    task automatic contend(input logic [31:0] ia, input logic [31:0] da);
        bit first_d;
        int kd, ki;
        @(posedge clk); #1;
        if_ce = 1'b1; if_addr = ia;
        d_ce = 1'b1; d_we = 1'b0; d_addr = da; d_sel = 4'hF;
`ifdef SOPC_MEM_ROUND_ROBIN_EN
        first_d = ptr_m;
`else
        first_d = 1'b1;
`endif
        if (first_d) begin
            model_commit(1'b1, 1'b0, da, 4'hF, 32'd0);
            model_commit(1'b0, 1'b0, ia, 4'hF, 32'd0);
        end else begin
            model_commit(1'b0, 1'b0, ia, 4'hF, 32'd0);
            model_commit(1'b1, 1'b0, da, 4'hF, 32'd0);
        end
        kd = 0; ki = 0;
        for (int k = 1; k <= 40 && (kd == 0 || ki == 0); k++) begin
            @(posedge clk); #1;
            if (d_ready)  begin kd = k; d_ce = 1'b0;  chk("cont_d_rdata", d_rdata, exp_drd); end
            if (if_ready) begin ki = k; if_ce = 1'b0; chk("cont_if_data", if_data, exp_ifd); end
        end
        d_ce = 1'b0; if_ce = 1'b0;
        chk("cont_d_cycle",  32'(kd), first_d ? 32'(LAT+1) : 32'(2*LAT+3));
        chk("cont_if_cycle", 32'(ki), first_d ? 32'(2*LAT+3) : 32'(LAT+1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pulsed;
        rst = 1'b0; if_ce = 1'b0; if_addr = '0;
        d_ce = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = '0; d_wdata = '0;
        exp_ifd = '0; exp_drd = '0; ptr_m = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // Initialise every word so the model has defined contents.
        for (int i = 0; i < 2**DL2; i++) access(1'b1, 1'b1, 32'(i*4), 4'hF, $urandom);

        access(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        chk("full_word", d_rdata, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'h100, 4'b0001, 32'h000000AA);
        chk("write_keeps_rdata", d_rdata, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'h100, 4'b1000, 32'h55000000);
        access(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        chk("byte_lanes", d_rdata, 32'h55ADBEAA);

        access(1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678);
        access(1'b1, 1'b0, 32'h00, 4'hF, 32'h0);
        chk("alias", d_rdata, 32'h12345678);
        access(1'b0, 1'b0, 32'h00, 4'h0, 32'h0);
        chk("if_alias", if_data, 32'h12345678);

        access(1'b1, 1'b1, 32'h0, 4'hF, 32'h11111111);
        access(1'b1, 1'b1, 32'h4, 4'hF, 32'h22222222);
        for (int p = 0; p < 3; p++) contend(32'h0, 32'h4);
        chk("cont_if_value", if_data, 32'h11111111);

        // Reset during ACCESS of a write must not commit it.
        access(1'b1, 1'b1, 32'h8, 4'hF, 32'h0);
        @(posedge clk); #1;
        d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_sel = 4'hF; d_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0; d_ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_ifd = '0; exp_drd = '0; ptr_m = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        chk("mid_rst_if_data", if_data, 32'd0);
        pulsed = 0;
        repeat (2*LAT+4) begin
            @(posedge clk); #1;
            if (d_ready || if_ready || busy) pulsed = 1;
        end
        chk("mid_no_ready", {31'd0, pulsed}, 32'd0);
        access(1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        chk("mid_not_committed", d_rdata, 32'h0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: access(1'b0, 1'b0, $urandom, 4'h0, 32'h0);
                1: access(1'b1, 1'b0, $urandom, 4'hF, 32'h0);
                2: access(1'b1, 1'b1, $urandom, 4'($urandom_range(1, 15)), $urandom);
                default: contend($urandom, $urandom);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
